// File: rtl/sram_if_pkg.sv
// Shared definitions for the SRAM request/response responders and the core that talks to them.
package sram_if_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StResp = 2'd2
  } sram_state_e;

  localparam logic [31:0] SramBaseAddr = 32'h1c000000;
  // Reset PC sits one word below the window so the first fetch after +4 hits word 0.
  localparam logic [31:0] ResetPcAddr  = 32'h1bfffffc;

  localparam int unsigned CntW = 4;

endpackage

// File: rtl/sram_resp_array.sv
// Word array with per-byte write enables and a registered, clearable read port.
module sram_resp_array #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] idx,
  input  logic [31:0]       wdata,
  input  logic              re,
  input  logic              rclr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];
  logic [31:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Read register holds its value unless a read or a clear is requested.
  always_comb begin
    rdata_d = rdata_q;
    if (rclr) begin
      rdata_d = '0;
    end else if (re) begin
      rdata_d = mem[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sram_resp_slave.sv
// Multi-cycle SRAM responder: one outstanding request, fixed latency, req/addr_ok/data_ok handshake.
module sram_resp_slave
  import sram_if_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = SramBaseAddr
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        resp_err
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("sram_resp_slave: LATENCY must be in 1..15");
  end
  if ((BASE_ADDR & ((32'd4 << ADDR_W) - 32'd1)) != 32'd0) begin : g_bad_base
    $error("sram_resp_slave: BASE_ADDR must be aligned to the window size");
  end

  sram_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wr_q, wr_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            data_ok_q, data_ok_d;
  logic            err_q, err_d;

  logic            fire;
  logic            txn_wr;
  logic [3:0]      txn_wstrb;
  logic [31:0]     txn_addr;
  logic [31:0]     txn_wdata;
  logic [31:0]     txn_off;
  logic            txn_legal;

  assign addr_ok = (state_q == StIdle) && !reset;

  // With LATENCY==1 the response is launched on the accept edge, before fields are latched.
  always_comb begin
    if (state_q == StIdle) begin
      txn_wr    = wr;
      txn_wstrb = wstrb;
      txn_addr  = addr;
      txn_wdata = wdata;
    end else begin
      txn_wr    = wr_q;
      txn_wstrb = wstrb_q;
      txn_addr  = addr_q;
      txn_wdata = wdata_q;
    end
  end

  // Subtraction wraps addresses below the base to large offsets, so one bound check suffices.
  assign txn_off   = txn_addr - BASE_ADDR;
  assign txn_legal = (txn_off[1:0] == 2'b00) && ((txn_off >> (ADDR_W + 2)) == 32'd0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    wstrb_d   = wstrb_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    fire      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req && addr_ok) begin
          wr_d    = wr;
          wstrb_d = wstrb;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = CntW'(LATENCY - 1);
          if (LATENCY > 1) begin
            state_d = StBusy;
          end else begin
            state_d = StResp;
            fire    = 1'b1;
          end
        end
      end
      StBusy: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          state_d = StResp;
          fire    = 1'b1;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    data_ok_d = fire;
    err_d     = fire && !txn_legal;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      wstrb_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      data_ok_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      wstrb_q   <= wstrb_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      data_ok_q <= data_ok_d;
      err_q     <= err_d;
    end
  end

  sram_resp_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk  (clk),
    .reset(reset),
    .we   (fire && txn_wr && txn_legal && !reset),
    .be   (txn_wstrb),
    .idx  (txn_off[ADDR_W+1:2]),
    .wdata(txn_wdata),
    .re   (fire && !txn_wr && txn_legal && !reset),
    .rclr (fire && !txn_legal),
    .rdata(rdata)
  );

  assign data_ok  = data_ok_q;
  assign resp_err = err_q;

endmodule

// File: tb/tb_sram_resp_slave.sv
// Scoreboard bench: one LATENCY=2 responder for data checks, four more for latency/reset behaviour.
module tb_sram_resp_slave;

  localparam logic [31:0] Base  = 32'h1c000000;
  localparam logic [15:0] Lats  = {4'd4, 4'd15, 4'd3, 4'd1};
  localparam int          Words = 1024;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Main DUT
  logic        rst0, req0, wr0, addr_ok0, data_ok0, err0;
  logic [3:0]  wstrb0;
  logic [31:0] addr0, wdata0, rdata0;

  sram_resp_slave #(
    .ADDR_W   (10),
    .LATENCY  (2),
    .BASE_ADDR(Base)
  ) u_dut (
    .clk     (clk),
    .reset   (rst0),
    .req     (req0),
    .wr      (wr0),
    .wstrb   (wstrb0),
    .addr    (addr0),
    .wdata   (wdata0),
    .addr_ok (addr_ok0),
    .data_ok (data_ok0),
    .rdata   (rdata0),
    .resp_err(err0)
  );

  // Latency sweep DUTs
  logic        rst_s [4];
  logic        req_s [4];
  logic        wr_s  [4];
  logic [3:0]  strb_s[4];
  logic [31:0] addr_s[4];
  logic [31:0] wd_s  [4];
  logic [31:0] rd_s  [4];
  logic        aok_s [4];
  logic        dok_s [4];
  logic        err_s [4];

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    sram_resp_slave #(
      .ADDR_W   (10),
      .LATENCY  (int'(Lats[g*4 +: 4])),
      .BASE_ADDR(Base)
    ) u_dut_s (
      .clk     (clk),
      .reset   (rst_s[g]),
      .req     (req_s[g]),
      .wr      (wr_s[g]),
      .wstrb   (strb_s[g]),
      .addr    (addr_s[g]),
      .wdata   (wd_s[g]),
      .addr_ok (aok_s[g]),
      .data_ok (dok_s[g]),
      .rdata   (rd_s[g]),
      .resp_err(err_s[g])
    );
  end

  // Reference model for the main DUT
  logic [31:0] mdl [Words];
  logic [31:0] last_rd = '0;
  exp_t        sb_q [$];

  function automatic logic [31:0] pat(input int i);
    logic [31:0] v;
    v = 32'(i);
    return (v * 32'h9e3779b1) ^ 32'h13572468;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (data_ok0) begin
      if (sb_q.size() == 0) begin
        chk("spurious_data_ok", {31'd0, data_ok0}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("rdata", rdata0, e.rdata);
        chk("resp_err", {31'd0, err0}, {31'd0, e.err});
        chk("latency", cyc, e.due);
      end
    end else begin
      chk("err_without_data_ok", {31'd0, err0}, 32'd0);
    end
  end

  // Starts and ends on a negedge; the next request can go out immediately after return.
  task automatic txn(input logic w, input logic [3:0] s, input logic [31:0] a,
                     input logic [31:0] d);
    exp_t   e;
    int     n;
    logic   legal;
    int     idx;
    req0 = 1'b1; wr0 = w; wstrb0 = s; addr0 = a; wdata0 = d;
    n = 0;
    while (!addr_ok0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!addr_ok0) begin
      chk("accept", {31'd0, addr_ok0}, 32'd1);
      req0 = 1'b0;
      return;
    end
    legal = (a[1:0] == 2'b00) && (a >= Base) && (a < Base + 32'h1000);
    idx   = int'((a - Base) >> 2);
    if (!legal) begin
      last_rd = '0;
      e.err   = 1'b1;
    end else if (w) begin
      mdl[idx] = merge(mdl[idx], d, s);
      e.err    = 1'b0;
    end else begin
      last_rd = mdl[idx];
      e.err   = 1'b0;
    end
    e.rdata = last_rd;
    e.due   = cyc + 2;
    sb_q.push_back(e);
    @(negedge clk);
    req0 = 1'b0;
    n = 0;
    while (!data_ok0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("data_ok_seen", {31'd0, data_ok0}, 32'd1);
    @(negedge clk);
    chk("addr_ok_after_resp", {31'd0, addr_ok0}, 32'd1);
  endtask

  task automatic s_txn(input int g, input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd);
    int n;
    req_s[g] = 1'b1; wr_s[g] = w; strb_s[g] = 4'hf; addr_s[g] = a; wd_s[g] = d;
    n = 0;
    while (!aok_s[g] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("s_accept", {31'd0, aok_s[g]}, 32'd1);
    @(negedge clk);
    req_s[g] = 1'b0;
    n = 0;
    while (!dok_s[g] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("s_data_ok_seen", {31'd0, dok_s[g]}, 32'd1);
    rd = rd_s[g];
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          last_acc [4];
    int          n_acc    [4];
    logic        prev_dok [4];
    logic [31:0] rd;
    int          lat;
    int          n;

    rst0 = 1'b1; req0 = 1'b0; wr0 = 1'b0; wstrb0 = '0; addr0 = '0; wdata0 = '0;
    for (int g = 0; g < 4; g++) begin
      rst_s[g] = 1'b1; req_s[g] = 1'b0; wr_s[g] = 1'b0; strb_s[g] = '0;
      addr_s[g] = '0; wd_s[g] = '0;
    end

    repeat (3) begin
      @(negedge clk);
      chk("rst_addr_ok", {31'd0, addr_ok0}, 32'd0);
      chk("rst_data_ok", {31'd0, data_ok0}, 32'd0);
      chk("rst_rdata", rdata0, 32'd0);
      chk("rst_resp_err", {31'd0, err0}, 32'd0);
    end
    rst0 = 1'b0;
    for (int g = 0; g < 4; g++) rst_s[g] = 1'b0;
    @(negedge clk);
    chk("addr_ok_after_reset", {31'd0, addr_ok0}, 32'd1);

    // Fill the whole array through the port so every word is known.
    for (int i = 0; i < Words; i++) begin
      mdl[i] = '0;
      txn(1'b1, 4'hf, Base + 32'(4 * i), (i == 0) ? 32'h02800421 : pat(i));
    end
    txn(1'b0, 4'hf, Base, 32'd0);

    txn(1'b1, 4'hf, Base + 32'h10, 32'hdeadbeef);
    txn(1'b1, 4'b0001, Base + 32'h10, 32'h000000aa);
    txn(1'b0, 4'h0, Base + 32'h10, 32'd0);

    txn(1'b0, 4'hf, Base + 32'h2, 32'd0);
    txn(1'b0, 4'hf, Base + 32'h1000, 32'd0);
    txn(1'b0, 4'hf, 32'h1bfffffc, 32'd0);
    txn(1'b0, 4'hf, Base + 32'h4, 32'd0);
    txn(1'b1, 4'hf, Base + 32'h1000, 32'hffffffff);
    txn(1'b1, 4'hf, Base + 32'h3, 32'hffffffff);
    txn(1'b1, 4'h0, Base + 32'h8, 32'hffffffff);
    for (int i = 0; i < Words; i++) txn(1'b0, 4'hf, Base + 32'(4 * i), 32'd0);

    for (int k = 0; k < 60; k++) begin
      logic [31:0] a;
      a = Base + 32'(4 * $urandom_range(0, Words - 1));
      if ($urandom_range(0, 7) == 0) a = a + 32'h1000;
      if ($urandom_range(0, 7) == 0) a = a | 32'h1;
      txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom);
    end
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    // Hold req high on all sweep instances and watch accept spacing.
    for (int g = 0; g < 4; g++) begin
      last_acc[g] = -1; n_acc[g] = 0; prev_dok[g] = 1'b0;
      req_s[g] = 1'b1; wr_s[g] = 1'b1; strb_s[g] = 4'hf; addr_s[g] = Base;
      wd_s[g] = 32'(g);
    end
    for (int k = 0; k < 120; k++) begin
      for (int g = 0; g < 4; g++) begin
        lat = int'(Lats[g*4 +: 4]);
        if (req_s[g] && aok_s[g]) begin
          if (last_acc[g] >= 0) chk("accept_spacing", cyc - last_acc[g], lat + 1);
          last_acc[g] = cyc;
          n_acc[g]++;
        end
        if (dok_s[g]) begin
          chk("data_ok_back_to_back", {31'd0, prev_dok[g]}, 32'd0);
          chk("sweep_latency", cyc - last_acc[g], lat);
          chk("sweep_err", {31'd0, err_s[g]}, 32'd0);
        end
        prev_dok[g] = dok_s[g];
      end
      @(negedge clk);
    end
    for (int g = 0; g < 4; g++) begin
      lat = int'(Lats[g*4 +: 4]);
      req_s[g] = 1'b0;
      chk("sweep_accept_count", n_acc[g], (120 + lat) / (lat + 1));
    end
    repeat (20) @(negedge clk);

    // Reset during a LATENCY=4 write must abort it before the array is touched.
    s_txn(3, 1'b1, Base + 32'h20, 32'hcafef00d, rd);
    req_s[3] = 1'b1; wr_s[3] = 1'b1; strb_s[3] = 4'hf; addr_s[3] = Base + 32'h20;
    wd_s[3] = 32'h12345678;
    n = 0;
    while (!aok_s[3] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("abort_accept", {31'd0, aok_s[3]}, 32'd1);
    @(negedge clk);
    req_s[3] = 1'b0;
    @(negedge clk);
    rst_s[3] = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_data_ok_in_reset", {31'd0, dok_s[3]}, 32'd0);
      chk("abort_addr_ok_in_reset", {31'd0, aok_s[3]}, 32'd0);
    end
    rst_s[3] = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_data_ok", {31'd0, dok_s[3]}, 32'd0);
    end
    s_txn(3, 1'b0, Base + 32'h20, 32'd0, rd);
    chk("abort_no_write", rd, 32'hcafef00d);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_resp_slave.md
Name: sram_resp_slave

Overview:
- Memory-side responder for the CPU's instruction and data SRAM requests, now that the core is moving from single-cycle to multi-cycle.
- Accepts one request at a time over a req/addr_ok/data_ok handshake.
- Models a configurable access latency and serves reads and writes from an internal word array.
- One instance serves the instruction port and another serves the data port. It replaces the zero-wait combinational SRAM model in the SoC-lite environment.

Parameters:
- ADDR_W, 10: word-index width; array holds 2^ADDR_W 32-bit words.
- LATENCY, 2: cycles from the accept edge to data_ok assertion. Legal range 1..15.
- BASE_ADDR, 32'h1c000000: byte address of word 0. Must be aligned to 4*2^ADDR_W.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req  in  1  request valid; initiator holds req and all request fields until addr_ok
- wr  in  1  1 = write, 0 = read
- wstrb  in  4  byte enables for writes; bit i covers wdata[8i+7:8i]; ignored for reads
- addr  in  32  byte address
- wdata  in  32  write data
- addr_ok  out  1  request accepted this cycle (handshake fires when req && addr_ok)
- data_ok  out  1  one-cycle response pulse
- rdata  out  32  read data, valid while data_ok=1
- resp_err  out  1  qualified by data_ok; address misaligned or out of range

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high.
- Reset values: state IDLE, data_ok=0, rdata=0, resp_err=0, counter=0. addr_ok=0 while reset is high. Array contents are not reset.
- addr_ok is combinational: (state==IDLE) && !reset. It does not depend on req.
- IDLE:
  - On req && addr_ok, latch wr, wstrb, addr and wdata.
  - Load counter with LATENCY-1.
  - Go to BUSY if LATENCY>1, otherwise go straight to RESP.
- BUSY:
  - Counter decrements each cycle.
  - When counter==1 at the edge, go to RESP.
  - req is ignored; addr_ok=0.
- Entry into RESP (the edge leaving BUSY, or leaving IDLE when LATENCY==1):
  - Write: if wr and the address is legal, bytes with wstrb=1 are written and other bytes keep their value. wstrb=0 is a legal no-op write.
  - Read: if !wr and the address is legal, rdata <= array[index]. rdata and data_ok are registered.
  - index = (addr - BASE_ADDR) >> 2.
- RESP:
  - data_ok=1 for exactly one cycle, then IDLE.
  - addr_ok=0 in RESP.
  - A request can be accepted on the cycle after data_ok.
- Latency: data_ok rises LATENCY cycles after the accept cycle. Throughput is one request per LATENCY+1 cycles.
- Legality:
  - A misaligned address (addr[1:0]!=0) or an address outside [BASE_ADDR, BASE_ADDR+4*2^ADDR_W) gives resp_err=1 and rdata=0, and no array write occurs.
  - Response timing is unchanged.
- rdata holds its last value after data_ok falls. rdata=0 after reset.
- resp_err is 0 whenever data_ok=0.
- Writes return data_ok with rdata unchanged from its previous value.
- Reset mid-transaction (BUSY or RESP): abort, go to IDLE, no array write, no data_ok.
- Read-after-write: a read accepted after the write's data_ok returns the new data.
- Counter width is 4 bits, fixed by the LATENCY ≤ 15 limit.
- Out-of-range LATENCY is a synthesis-time error via a generate-time check.

Decomposition:
- Shared package sram_if_pkg holds:
  - state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2)
  - the default BASE_ADDR constant 32'h1c000000
  - the constant for the reset PC trick (32'h1bfffffc), so the core and the responder agree on the start address.
- One sub-module, sram_resp_array: a 2^ADDR_W x 32 synchronous array with a 4-bit byte-write enable and a registered read port. It is instantiated once. The FSM, counter, address decode and error logic stay in sram_resp_slave.

Test Plan:
- LATENCY=2, preload word 0 = 32'h02800421; read at addr 32'h1c000000 -> addr_ok=1 in the accept cycle; data_ok=1 exactly 2 cycles later with rdata=32'h02800421 and resp_err=0; addr_ok=1 again the following cycle.
- Write 32'hdeadbeef with wstrb=4'hf to 32'h1c000010, then write 32'h000000aa with wstrb=4'b0001 to the same address, then read it -> rdata=32'hdeadbeaa.
- Sweep LATENCY=1,3,15 with req held high continuously -> accepts spaced exactly LATENCY+1 cycles apart; data_ok never high two cycles in a row; req during BUSY is not accepted.
- Read 32'h1c000002 (misaligned) and 32'h1c001000 (one past the end with ADDR_W=10) -> data_ok with resp_err=1 and rdata=0. A write to 32'h1c001000 leaves every array word unchanged.
- Accept a write of 32'h12345678 to 32'h1c000020 with LATENCY=4; assert reset 2 cycles after accept -> no data_ok; after reset, a read of 32'h1c000020 returns the preloaded value, not 32'h12345678.
- Reset held 3 cycles -> addr_ok=0, data_ok=0, rdata=0 and resp_err=0 throughout; addr_ok=1 on the first cycle after reset deasserts.
